// File: rtl/pulse_stretcher_multi.sv
// Multi-lane synchronous pulse stretcher with optional retrigger and low gap.
// Define PULSE_STRETCHER_MULTI_EDGE_TRIG_EN to trigger on rising edges of i_x.
module pulse_stretcher_multi #(
  parameter int par_channels       = 4,
  parameter int par_T_stretch_bits = 7,
  parameter int par_T_stretch_val  = 64,
  parameter int par_T_gap_val      = 0,
  parameter int par_retrigger      = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [par_channels-1:0] i_x,
  output logic [par_channels-1:0] o_y,
  output logic [par_channels-1:0] o_busy,
  output logic [par_channels-1:0] o_drop
);

  localparam int W = par_T_stretch_bits;
  localparam logic [W-1:0] HOLD_LAST = W'(par_T_stretch_val - 1);
  localparam logic [W-1:0] GAP_LAST =
    W'((par_T_gap_val > 0) ? par_T_gap_val - 1 : 0);
  localparam logic [W-1:0] T_MAX = '1;
  localparam bit RETRIG  = (par_retrigger != 0);
  localparam bit HAS_GAP = (par_T_gap_val != 0);

  // Gray-coded: 2'b10 is unused and falls back to idle
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_GAP  = 2'b11
  } state_t;

  logic [par_channels-1:0] trig;

`ifdef PULSE_STRETCHER_MULTI_EDGE_TRIG_EN
  logic [par_channels-1:0] x_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) x_q <= '0;
    else       x_q <= i_x;
  end

  assign trig = i_x & ~x_q;
`else
  assign trig = i_x;
`endif

  for (genvar n = 0; n < par_channels; n++) begin : g_lane
    state_t         state;
    logic [W-1:0]   timer;
    logic [W-1:0]   tmr_inc;

    assign tmr_inc = (timer == T_MAX) ? timer : timer + W'(1);

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state <= S_IDLE;
        timer <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (trig[n]) begin
              state <= S_HOLD;
              timer <= '0;
            end
          end
          S_HOLD: begin
            if (RETRIG && trig[n]) begin
              timer <= '0;
            end else if (timer == HOLD_LAST) begin
              state <= HAS_GAP ? S_GAP : S_IDLE;
              timer <= '0;
            end else begin
              timer <= tmr_inc;
            end
          end
          S_GAP: begin
            if (timer == GAP_LAST) begin
              state <= S_IDLE;
              timer <= '0;
            end else begin
              timer <= tmr_inc;
            end
          end
          default: begin
            state <= S_IDLE;
            timer <= '0;
          end
        endcase
      end
    end

    assign o_y[n]    = (state == S_HOLD);
    assign o_busy[n] = (state == S_HOLD) || (state == S_GAP);
    assign o_drop[n] = trig[n] &&
      ((state == S_GAP) || ((state == S_HOLD) && !RETRIG));
  end

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Directed bench for pulse_stretcher_multi: per-cycle vector table
// on a baseline instance plus sequences for retrigger, gap and T=1.
module tb_pulse_stretcher_multi;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_x;

  logic [3:0] y_b, busy_b, drop_b;
  logic [3:0] y_r, busy_r, drop_r;
  logic [3:0] y_g, busy_g, drop_g;
  logic [3:0] y_1, busy_1, drop_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretcher_multi #(
    .par_channels(4), .par_T_stretch_bits(7), .par_T_stretch_val(8),
    .par_T_gap_val(0), .par_retrigger(0)
  ) u_base (
    .i_clk(clk), .i_rst(i_rst), .i_x(i_x),
    .o_y(y_b), .o_busy(busy_b), .o_drop(drop_b)
  );

  pulse_stretcher_multi #(
    .par_channels(4), .par_T_stretch_bits(7), .par_T_stretch_val(8),
    .par_T_gap_val(0), .par_retrigger(1)
  ) u_rt (
    .i_clk(clk), .i_rst(i_rst), .i_x(i_x),
    .o_y(y_r), .o_busy(busy_r), .o_drop(drop_r)
  );

  pulse_stretcher_multi #(
    .par_channels(4), .par_T_stretch_bits(7), .par_T_stretch_val(8),
    .par_T_gap_val(3), .par_retrigger(0)
  ) u_gap (
    .i_clk(clk), .i_rst(i_rst), .i_x(i_x),
    .o_y(y_g), .o_busy(busy_g), .o_drop(drop_g)
  );

  pulse_stretcher_multi #(
    .par_channels(4), .par_T_stretch_bits(1), .par_T_stretch_val(1),
    .par_T_gap_val(0), .par_retrigger(0)
  ) u_t1 (
    .i_clk(clk), .i_rst(i_rst), .i_x(i_x),
    .o_y(y_1), .o_busy(busy_1), .o_drop(drop_1)
  );

  typedef struct {
    logic [3:0] x;
    logic       rst;
    logic [3:0] y;
    logic [3:0] busy;
    logic [3:0] drop;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [3:0] x, input logic rst,
                              input logic [3:0] y, input logic [3:0] busy,
                              input logic [3:0] drop, input int n);
    vec_t v;
    v.x = x; v.rst = rst; v.y = y; v.busy = busy; v.drop = drop;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endfunction

  // Inputs change at negedge; outputs are compared 1 time unit later,
  // showing the state left by the previous posedge and the current trig.
  task automatic step(input logic [3:0] x, input logic rst);
    @(negedge clk);
    i_x   = x;
    i_rst = rst;
    #1;
  endtask

  task automatic chk(input string name, input int row,
                     input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, got, exp);
    end
  endtask

  initial begin
    logic [3:0] ey, eb, ed;
    int p;

    i_rst = 1'b1;
    i_x   = '0;
    repeat (2) @(posedge clk);

    // reset state
    add(0, 0, 0, 0, 0, 2);
    // single trigger on lane 0
    add(1, 0, 0, 0, 0, 1); add(0, 0, 1, 1, 0, 8); add(0, 0, 0, 0, 0, 1);
    // lane 1: ignored trigger mid-hold and on the final hold cycle
    add(2, 0, 0, 0, 0, 1); add(0, 0, 2, 2, 0, 3); add(2, 0, 2, 2, 2, 1);
    add(0, 0, 2, 2, 0, 3); add(2, 0, 2, 2, 2, 1); add(0, 0, 0, 0, 0, 1);
    // simultaneous lanes 2 and 3
    add(12, 0, 0, 0, 0, 1); add(0, 0, 12, 12, 0, 8); add(0, 0, 0, 0, 0, 1);
    // lane 0 level held high
`ifdef PULSE_STRETCHER_MULTI_EDGE_TRIG_EN
    add(1, 0, 0, 0, 0, 1); add(1, 0, 1, 1, 0, 8);
    add(1, 0, 0, 0, 0, 3); add(0, 0, 0, 0, 0, 1);
`else
    add(1, 0, 0, 0, 0, 1); add(1, 0, 1, 1, 1, 8); add(1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 1); add(0, 0, 1, 1, 0, 7); add(0, 0, 0, 0, 0, 1);
`endif
    // reset in the 6th hold cycle, then a full pulse right after
    add(1, 0, 0, 0, 0, 1); add(0, 0, 1, 1, 0, 5); add(0, 1, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1); add(0, 0, 1, 1, 0, 8); add(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].x, vq[i].rst);
      chk("base_y", i, y_b, vq[i].y);
      chk("base_busy", i, busy_b, vq[i].busy);
      chk("base_drop", i, drop_b, vq[i].drop);
    end

    // lane 1 triggers at rows 0 and 4: retrigger extends, base ignores
    step(0, 1);
    for (int i = 0; i < 15; i++) begin
      step((i == 0 || i == 4) ? 4'd2 : 4'd0, 1'b0);
      chk("rt_y", i, {3'b0, y_r[1]}, {3'b0, (i >= 1 && i <= 12)});
      chk("rt_drop", i, drop_r, 4'd0);
      chk("nrt_y", i, {3'b0, y_b[1]}, {3'b0, (i >= 1 && i <= 8)});
      chk("nrt_drop", i, {3'b0, drop_b[1]}, {3'b0, (i == 4)});
    end

    // lane 2 held high with a 3-cycle gap
    step(0, 1);
    for (int i = 0; i < 36; i++) begin
      step(4'd4, 1'b0);
      p = i % 12;
      ey = (p >= 1 && p <= 8) ? 4'd4 : 4'd0;
      eb = (p >= 1) ? 4'd4 : 4'd0;
`ifdef PULSE_STRETCHER_MULTI_EDGE_TRIG_EN
      ed = 4'd0;
      if (i >= 12) begin
        ey = 4'd0;
        eb = 4'd0;
      end
`else
      ed = (p >= 1) ? 4'd4 : 4'd0;
`endif
      chk("gap_y", i, y_g, ey);
      chk("gap_busy", i, busy_g, eb);
      chk("gap_drop", i, drop_g, ed);
    end

    // single-cycle stretch; trigger on its only hold cycle is dropped
    step(0, 1);
    step(1, 0);
    chk("t1_y", 0, y_1, 4'd0);
    step(1, 0);
    chk("t1_y", 1, y_1, 4'd1);
    chk("t1_busy", 1, busy_1, 4'd1);
`ifdef PULSE_STRETCHER_MULTI_EDGE_TRIG_EN
    chk("t1_drop", 1, drop_1, 4'd0);
`else
    chk("t1_drop", 1, drop_1, 4'd1);
`endif
    step(0, 0);
    chk("t1_y", 2, y_1, 4'd0);
    chk("t1_busy", 2, busy_1, 4'd0);
    step(0, 0);
    chk("t1_y", 3, y_1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
